dec_unbinder_seq: RTL

- Decode-side counterpart of the encoder binder pack.
- Accepts a frame of NUM_BIND bound (shifted) hypervectors, one per beat, on a valid/ready stream.
- Undoes each beat's permutation binding by rotating it right by SHIFTS[SHIFT_BASE + beat index], so the original level HV is recovered.
- Sits between the query/retrieval path and level-HV similarity lookup; a single rotator is time-multiplexed instead of NUM_BIND parallel unbinders.

---
 rtl/hdc_pkg.sv | 33 +++
 rtl/hv_rotr.sv | 21 ++
 rtl/dec_unbinder_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hdc_pkg.sv
// Shared hypervector constants, the permutation shift table, and the rotate helper
// used by every binder and unbinder.
package hdc_pkg;

  localparam int HV_DIM     = 64;
  localparam int HV_AW      = $clog2(HV_DIM);
  localparam int HV_ONES    = HV_DIM / 2;
  localparam int NUM_SHIFTS = 288;

  typedef logic [HV_DIM-1:0] hv_t;

  // Entries past HV_DIM exercise the modulo reduction; 279 wraps to a zero rotate.
  localparam int SHIFTS [NUM_SHIFTS] = '{
    270: 0,
    271: HV_DIM - 1,
    272: 5,
    273: 17,
    274: 100,
    275: 32,
    276: 1,
    277: 129,
    278: 42,
    279: 64,
    default: 3
  };

  function automatic hv_t rotr_hv(hv_t v, int s);
    int unsigned sm;
    sm = int'(s % HV_DIM);
    return (v >> sm) | (v << (HV_DIM - sm));
  endfunction

endpackage

// File: rtl/hv_rotr.sv
// Combinational barrel rotator: rotates right by sel_i using one mux stage
// per select bit.
module hv_rotr
  import hdc_pkg::*;
(
  input  logic [HV_DIM-1:0] hv_i,
  input  logic [HV_AW-1:0]  sel_i,
  output logic [HV_DIM-1:0] hv_o
);

  hv_t stage_v;

  always_comb begin
    stage_v = hv_i;
    for (int k = 0; k < HV_AW; k++) begin
      if (sel_i[k]) stage_v = rotr_hv(stage_v, 1 << k);
    end
    hv_o = stage_v;
  end

endmodule

// File: rtl/dec_unbinder_seq.sv
// Sequential permutation unbinder: one rotator undoes NUM_BIND bound beats per frame.
// Optional popcount/density outputs are enabled with DEC_UNBINDER_POPCNT_EN.
module dec_unbinder_seq #(
  parameter int HV_DIM     = hdc_pkg::HV_DIM,
  parameter int NUM_BIND   = 10,
  parameter int SHIFT_BASE = 270
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start_decoding,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [HV_DIM-1:0]           shifted_hv,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [HV_DIM-1:0]           level_hv,
  output logic [$clog2(NUM_BIND)-1:0] out_idx,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
`ifdef DEC_UNBINDER_POPCNT_EN
  , output logic [$clog2(HV_DIM+1)-1:0] density
  , output logic                        sparse_err
`endif
);

  import hdc_pkg::*;

  localparam int IW = $clog2(NUM_BIND);
  localparam int AW = $clog2(HV_DIM);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BIND - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [HV_DIM-1:0] level_q, level_d;
  logic [IW-1:0]     out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [AW-1:0]     shift_tbl [NUM_BIND];
  logic [AW-1:0]     shamt;
  logic [HV_DIM-1:0] rot_hv;
  logic              accept;
  logic              handoff;

  // Per-beat rotate amounts, already reduced modulo HV_DIM.
  for (genvar b = 0; b < NUM_BIND; b++) begin : g_shift
    assign shift_tbl[b] = AW'(SHIFTS[SHIFT_BASE + b] % HV_DIM);
  end

  assign shamt = shift_tbl[idx_q];

  hv_rotr u_rotr (
    .hv_i  (shifted_hv),
    .sel_i (shamt),
    .hv_o  (rot_hv)
  );

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    level_d     = level_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_decoding) begin
          state_d = RUN;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          level_d     = rot_hv;
          out_idx_d   = idx_q;
          out_last_d  = (idx_q == LAST_IDX);
          out_valid_d = 1'b1;
          if (idx_q == LAST_IDX) state_d = FLUSH;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      FLUSH: begin
        if (handoff) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      level_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign level_hv  = level_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef DEC_UNBINDER_POPCNT_EN
  localparam int DW = $clog2(HV_DIM + 1);

  logic [DW-1:0] density_q;

  function automatic logic [DW-1:0] popcnt(logic [HV_DIM-1:0] v);
    logic [DW-1:0] c;
    c = '0;
    for (int k = 0; k < HV_DIM; k++) c = c + DW'(v[k]);
    return c;
  endfunction

  // Density is captured with the same beat as level_hv.
  always_ff @(posedge clk) begin
    if (nrst)             density_q <= '0;
    else if (accept)      density_q <= popcnt(rot_hv);
  end

  assign density    = density_q;
  assign sparse_err = out_valid_q && (density_q != DW'(HV_ONES));
`endif

endmodule
